sba_mem_bridge: RTL and testbench

SBA_MEM_BRIDGE -- requirements
Module: sba_mem_bridge

---
 rtl/sba_mem_bridge.sv | 120 ++++++++++++
 tb/tb_sba_mem_bridge.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sba_mem_bridge.sv
// sba_mem_bridge: bridges 64-bit debug-module SBA accesses onto a 32-bit memory port as LO/HI beats.
// Ports: clk_i/rst_ni (async active-low); sba_* request/grant/response side; mem_* 32-bit beat side.
// Writes are only supported when SBA_MEM_BRIDGE_WRITE_EN is defined; otherwise they answer with err=1.
module sba_mem_bridge #(
  parameter int unsigned MemAddrWidth = 16,
  parameter logic [63:0] MemBase      = 64'h0,
  parameter logic [63:0] MemSize      = 64'h4000,
  parameter int unsigned MemLatency   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sba_req_i,
  input  logic                    sba_we_i,
  input  logic [63:0]             sba_addr_i,
  input  logic [63:0]             sba_wdata_i,
  input  logic [7:0]              sba_be_i,
  output logic                    sba_gnt_o,
  output logic                    sba_rvalid_o,
  output logic [63:0]             sba_rdata_o,
  output logic                    sba_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  output logic [3:0]              mem_be_o,
  input  logic [31:0]             mem_rdata_i
);
  typedef enum logic [2:0] {IDLE, LO, LOWAIT, HI, HIWAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d;
  logic [MemAddrWidth-4:0] off_q, off_d;
  logic [63:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0] be_q, be_d;
  logic [64:0] diff;
  logic in_range, hi;
`ifdef SBA_MEM_BRIDGE_WRITE_EN
  localparam logic WrEn = 1'b1;
  assign mem_we_o = mem_req_o & we_q;
`else
  localparam logic WrEn = 1'b0;
  assign mem_we_o = 1'b0;
`endif
  // 65-bit subtraction: the borrow bit flags addr < MemBase without overflow at the top of the map
  assign diff = {1'b0, sba_addr_i} - {1'b0, MemBase};
  assign in_range = !diff[64] && diff[63:0] < MemSize;
  assign hi = state_q == HI;
  assign sba_gnt_o = rst_ni && state_q == IDLE && sba_req_i;
  assign sba_rvalid_o = state_q == RESP;
  assign sba_rdata_o = rdata_q;
  assign sba_err_o = err_q;
  assign mem_req_o = state_q == LO || state_q == HI;
  assign mem_addr_o = {off_q, hi, 2'b00};
  assign mem_wdata_o = hi ? wdata_q[63:32] : wdata_q[31:0];
  assign mem_be_o = !we_q ? 4'hF : hi ? be_q[7:4] : be_q[3:0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    err_d = err_q;
    off_d = off_q;
    wdata_d = wdata_q;
    be_d = be_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (sba_req_i) begin
        we_d = sba_we_i;
        off_d = diff[MemAddrWidth-1:3];
        wdata_d = sba_wdata_i;
        be_d = sba_be_i;
        rdata_d = '0;
        err_d = !in_range || (sba_we_i && !WrEn);
        state_d = err_d ? RESP : !sba_we_i ? LO : |sba_be_i[3:0] ? LO : |sba_be_i[7:4] ? HI : RESP;
      end
      LO: begin
        cnt_d = '0;
        state_d = !we_q ? LOWAIT : |be_q[7:4] ? HI : RESP;
      end
      LOWAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(MemLatency - 1)) begin
          rdata_d[31:0] = mem_rdata_i;
          cnt_d = '0;
          state_d = HI;
        end
      end
      HI: state_d = we_q ? RESP : HIWAIT;
      HIWAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(MemLatency - 1)) begin
          rdata_d[63:32] = mem_rdata_i;
          cnt_d = '0;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      off_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      err_q <= err_d;
      off_q <= off_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_sba_mem_bridge.sv
// tb_sba_mem_bridge: directed plus random checks of sba_mem_bridge against a word-array reference model.
module tb_sba_mem_bridge;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic sba_req_i = 1'b0, sba_we_i = 1'b0;
  logic [63:0] sba_addr_i = '0, sba_wdata_i = '0;
  logic [7:0] sba_be_i = '0;
  logic sba_gnt_o, sba_rvalid_o, sba_err_o, mem_req_o, mem_we_o;
  logic [63:0] sba_rdata_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i = '0;
  logic [3:0] mem_be_o;
`ifdef SBA_MEM_BRIDGE_WRITE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  logic [52:0] beats [$];
  int total = 0, bad = 0;

  sba_mem_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sba_req_i(sba_req_i), .sba_we_i(sba_we_i),
    .sba_addr_i(sba_addr_i), .sba_wdata_i(sba_wdata_i), .sba_be_i(sba_be_i),
    .sba_gnt_o(sba_gnt_o), .sba_rvalid_o(sba_rvalid_o), .sba_rdata_o(sba_rdata_o),
    .sba_err_o(sba_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // memory with one cycle of read latency
  always @(posedge clk_i)
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o[13:2]][8*b+:8] <= mem_wdata_o[8*b+:8];
      end else mem_rdata_i <= mem[mem_addr_o[13:2]];
    end

  always @(negedge clk_i)
    if (mem_req_o) beats.push_back({mem_we_o, mem_addr_o, mem_be_o, mem_we_o ? mem_wdata_o : 32'h0});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] be, input string tag);
    logic [52:0] exp_beats [$];
    logic [63:0] exp_rdata;
    logic exp_err;
    logic [15:0] a0;
    int exp_lat, n, w;
    exp_err = 1'b0;
    exp_rdata = '0;
    a0 = {2'b00, addr[13:3], 3'b000};
    w = int'(addr[13:3]) * 2;
    if (addr >= 64'h4000 || (we && !WEN)) begin
      exp_err = 1'b1;
      exp_lat = 1;
    end else if (we) begin
      for (int h = 0; h < 2; h++)
        if (be[4*h+:4] != 4'h0) begin
          exp_beats.push_back({1'b1, a0 + 16'(h * 4), be[4*h+:4], wdata[32*h+:32]});
          for (int b = 0; b < 4; b++)
            if (be[4*h+b]) ref_mem[w+h][8*b+:8] = wdata[32*h+8*b+:8];
        end
      exp_lat = 1 + exp_beats.size();
    end else begin
      for (int h = 0; h < 2; h++) exp_beats.push_back({1'b0, a0 + 16'(h * 4), 4'hF, 32'h0});
      exp_rdata = {ref_mem[w+1], ref_mem[w]};
      exp_lat = 5;
    end
    @(posedge clk_i);
    #1;
    sba_req_i = 1'b1;
    sba_we_i = we;
    sba_addr_i = addr;
    sba_wdata_i = wdata;
    sba_be_i = be;
    beats.delete();
    #1 check({tag, "_gnt"}, sba_gnt_o, 1);
    @(posedge clk_i);
    #1 sba_req_i = 1'b0;
    n = 1;
    while (!sba_rvalid_o && n < 20) begin
      @(posedge clk_i);
      #1 n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_err"}, sba_err_o, exp_err);
    check({tag, "_rdata"}, sba_rdata_o, exp_rdata);
    check({tag, "_nbeats"}, beats.size(), exp_beats.size());
    for (int i = 0; i < beats.size() && i < exp_beats.size(); i++)
      check({tag, "_beat"}, beats[i], exp_beats[i]);
    @(posedge clk_i);
    #1 check({tag, "_pulse"}, sba_rvalid_o, 0);
  endtask

  initial begin
    logic [63:0] a, exp2;
    logic [7:0] be;
    int cnt;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hAAAA5555; ref_mem[4] = 32'hAAAA5555;
    mem[5] = 32'h12345678; ref_mem[5] = 32'h12345678;
    #1 sba_req_i = 1'b1;
    #1;
    check("rst_gnt", sba_gnt_o, 0);
    check("rst_rvalid", sba_rvalid_o, 0);
    check("rst_err", sba_err_o, 0);
    check("rst_memreq", mem_req_o, 0);
    check("rst_memwe", mem_we_o, 0);
    check("rst_rdata", sba_rdata_o, 0);
    sba_req_i = 1'b0;
    #20;
    @(negedge clk_i) rst_ni = 1'b1;
    txn(1'b0, 64'h10, 64'h0, 8'hFF, "rd41");
    check("rd41_const", sba_rdata_o, 64'h12345678AAAA5555);
    txn(1'b0, 64'h4000, 64'h0, 8'hFF, "oor42");
    txn(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'hFF, "oor_top");
    txn(1'b0, 64'h3FFF, 64'h0, 8'hFF, "rd_last");
    txn(1'b1, 64'h20, 64'hDEADBEEF_00000000, 8'hF0, "wr43");
    txn(1'b1, 64'h0, 64'h01234567_89ABCDEF, 8'hFF, "wr46");
    txn(1'b1, 64'h28, 64'h55555555_55555555, 8'h00, "wr_be0");
    txn(1'b1, 64'h30, 64'hCAFEF00D_87654321, 8'h0F, "wr_lo");
    txn(1'b0, 64'h20, 64'h0, 8'hFF, "rd_wr");
    txn(1'b0, 64'h30, 64'h0, 8'hFF, "rd_wr2");
    // request held high: grants only at acceptance and the cycle after rvalid
    exp2 = {ref_mem[5], ref_mem[4]};
    @(posedge clk_i);
    #1;
    sba_req_i = 1'b1;
    sba_we_i = 1'b0;
    sba_addr_i = 64'h10;
    sba_be_i = 8'hFF;
    #1 check("hold_gnt0", sba_gnt_o, 1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk_i);
      #1;
      check("hold_gnt", sba_gnt_o, k == 6);
      check("hold_rvalid", sba_rvalid_o, k == 5);
      if (k == 5) check("hold_rdata", sba_rdata_o, exp2);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 1) sba_req_i = 1'b0;
      check("hold2_rvalid", sba_rvalid_o, k == 5);
    end
    check("hold2_rdata", sba_rdata_o, exp2);
    // reset pulsed while waiting for the LO beat data
    @(posedge clk_i);
    #1;
    sba_req_i = 1'b1;
    sba_addr_i = 64'h18;
    @(posedge clk_i);
    #1 sba_req_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    sba_req_i = 1'b1;
    #1;
    check("mid_rst_gnt", sba_gnt_o, 0);
    check("mid_rst_rvalid", sba_rvalid_o, 0);
    check("mid_rst_err", sba_err_o, 0);
    check("mid_rst_memreq", mem_req_o, 0);
    check("mid_rst_memwe", mem_we_o, 0);
    check("mid_rst_rdata", sba_rdata_o, 0);
    sba_req_i = 1'b0;
    #2 rst_ni = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i);
      #1 cnt += int'(sba_rvalid_o);
    end
    check("mid_rst_norvalid", cnt, 0);
    txn(1'b0, 64'h18, 64'h0, 8'hFF, "post_rst");
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 32'h47FF));
      be = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      txn(1'($urandom), a, {$urandom, $urandom}, be, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
